// File: rtl/adaptive_traffic_controller.sv
// Two-road (NS/EW) intersection sequencer with programmable phase lengths,
// all-red clearance, latched pedestrian service, emergency preemption and
// night flash. Every output is a register, and phase mirrors the state register.
//
// Handshake note: the block has no valid/ready handshakes. ped_req is a
// level that is sampled on every rising edge and latched into ped_pending.
// emerg_req and flash_mode are levels that are sampled on every rising edge.
module adaptive_traffic_controller #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_TICKS    = 5,
  parameter int FLASH_TICKS  = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  input  logic       flash_mode,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_NS_G  = 3'd0,
    S_NS_Y  = 3'd1,
    S_AR1   = 3'd2,
    S_EW_G  = 3'd3,
    S_EW_Y  = 3'd4,
    S_AR2   = 3'd5,
    S_PED   = 3'd6,
    S_FLASH = 3'd7
  } state_t;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;
  localparam logic [1:0] L_OFF    = 2'b11;

  // Timer reload values: a phase dwells TICKS cycles, so the timer counts TICKS-1 down to 0.
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(PED_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic             flash_on, flash_on_next;     // 1 = yellow half of flash, 0 = dark half
  logic             ped_ret_ew, ped_ret_ew_next; // green to resume after a walk phase
  logic             ped_pending_next;
  logic [1:0]       ns_next, ew_next;
  logic             walk_next;
  logic             timer_zero;
  state_t           wanted_green;

  assign timer_zero   = (timer == '0);
  assign wanted_green = emerg_dir ? S_EW_G : S_NS_G;
  assign phase        = state;

  // Next-state and timer logic, which includes emergency, flash and pedestrian arbitration
  always_comb begin
    state_next      = state;
    timer_next      = timer_zero ? timer : timer - ONE;
    flash_on_next   = flash_on;
    ped_ret_ew_next = ped_ret_ew;
    case (state)
      S_NS_G: begin
        if (emerg_req && !emerg_dir) begin
          timer_next = LD_GREEN;            // wanted direction already green: hold
        end else if ((emerg_req && emerg_dir) || timer_zero) begin
          state_next = S_NS_Y;
          timer_next = LD_YELLOW;
        end
      end
      S_EW_G: begin
        if (emerg_req && emerg_dir) begin
          timer_next = LD_GREEN;
        end else if ((emerg_req && !emerg_dir) || timer_zero) begin
          state_next = S_EW_Y;
          timer_next = LD_YELLOW;
        end
      end
      S_NS_Y: begin
        if (timer_zero) begin
          state_next = S_AR1;
          timer_next = LD_ALLRED;
        end
      end
      S_EW_Y: begin
        if (timer_zero) begin
          state_next = S_AR2;
          timer_next = LD_ALLRED;
        end
      end
      S_AR1, S_AR2: begin
        if (timer_zero) begin
          if (emerg_req) begin
            state_next = wanted_green;
            timer_next = LD_GREEN;
          end else if (flash_mode) begin
            state_next    = S_FLASH;
            timer_next    = LD_FLASH;
            flash_on_next = 1'b1;
          end else if (ped_pending) begin
            state_next      = S_PED;
            timer_next      = LD_PED;
            ped_ret_ew_next = (state == S_AR1);
          end else begin
            state_next = (state == S_AR1) ? S_EW_G : S_NS_G;
            timer_next = LD_GREEN;
          end
        end
      end
      S_PED: begin
        if (timer_zero) begin
          if (emerg_req) state_next = wanted_green;
          else           state_next = ped_ret_ew ? S_EW_G : S_NS_G;
          timer_next = LD_GREEN;
        end
      end
      S_FLASH: begin
        if (timer_zero) begin
          if (emerg_req || (!flash_on && !flash_mode)) begin
            state_next = S_AR2;
            timer_next = LD_ALLRED;
          end else begin
            flash_on_next = !flash_on;
            timer_next    = LD_FLASH;
          end
        end
      end
      default: begin
        state_next = S_NS_G;
        timer_next = LD_GREEN;
      end
    endcase
  end

  // Pedestrian latch: any request sets it, entering the walk phase clears it
  always_comb begin
    ped_pending_next = ped_req || (ped_pending && !((state != S_PED) && (state_next == S_PED)));
  end

  // Signal-head decode of the upcoming state so the heads are registered with it
  always_comb begin
    ns_next   = L_RED;
    ew_next   = L_RED;
    walk_next = 1'b0;
    case (state_next)
      S_NS_G:  ns_next = L_GREEN;
      S_NS_Y:  ns_next = L_YELLOW;
      S_EW_G:  ew_next = L_GREEN;
      S_EW_Y:  ew_next = L_YELLOW;
      S_PED:   walk_next = 1'b1;
      S_FLASH: begin
        ns_next = flash_on_next ? L_YELLOW : L_OFF;
        ew_next = flash_on_next ? L_YELLOW : L_OFF;
      end
      default: ;
    endcase
  end

  // State, timer and output registers, which reset to the start of NS green
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_NS_G;
      timer       <= LD_GREEN;
      flash_on    <= 1'b0;
      ped_ret_ew  <= 1'b0;
      ped_pending <= 1'b0;
      ns_light    <= L_GREEN;
      ew_light    <= L_RED;
      ped_walk    <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      flash_on    <= flash_on_next;
      ped_ret_ew  <= ped_ret_ew_next;
      ped_pending <= ped_pending_next;
      ns_light    <= ns_next;
      ew_light    <= ew_next;
      ped_walk    <= walk_next;
    end
  end

endmodule

// File: tb/tb_adaptive_traffic_controller.sv
// Directed bench for adaptive_traffic_controller at default parameters,
// followed by a random soak with signal-head safety checks.
module tb_adaptive_traffic_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg_req = 1'b0;
  logic       emerg_dir = 1'b0;
  logic       flash_mode = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       ped_walk, ped_pending;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adaptive_traffic_controller dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .emerg_req(emerg_req),
    .emerg_dir(emerg_dir), .flash_mode(flash_mode), .ns_light(ns_light),
    .ew_light(ew_light), .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    ped_req = 1'b0; emerg_req = 1'b0; emerg_dir = 1'b0; flash_mode = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Compare {phase, ns, ew, walk, pending}
  task automatic expect_st(input string tag, input logic [2:0] ph, input logic [1:0] ns,
                           input logic [1:0] ew, input logic walk, input logic pend);
    chk(tag, {phase, ns_light, ew_light, ped_walk, ped_pending}, {ph, ns, ew, walk, pend});
  endtask

  int last_g;
  logic saw_y, saw_ar, bad;

  initial begin
    // 1: normal cycle
    do_reset();
    expect_st("t1_c0", 3'd0, 2'b10, 2'b00, 0, 0);
    goto(7);  expect_st("t1_c7", 3'd0, 2'b10, 2'b00, 0, 0);
    goto(8);  expect_st("t1_c8", 3'd1, 2'b01, 2'b00, 0, 0);
    goto(10); expect_st("t1_c10", 3'd1, 2'b01, 2'b00, 0, 0);
    goto(11); expect_st("t1_c11", 3'd2, 2'b00, 2'b00, 0, 0);
    goto(12); expect_st("t1_c12", 3'd2, 2'b00, 2'b00, 0, 0);
    goto(13); expect_st("t1_c13", 3'd3, 2'b00, 2'b10, 0, 0);
    goto(20); expect_st("t1_c20", 3'd3, 2'b00, 2'b10, 0, 0);
    goto(21); expect_st("t1_c21", 3'd4, 2'b00, 2'b01, 0, 0);
    goto(23); expect_st("t1_c23", 3'd4, 2'b00, 2'b01, 0, 0);
    goto(24); expect_st("t1_c24", 3'd5, 2'b00, 2'b00, 0, 0);
    goto(25); expect_st("t1_c25", 3'd5, 2'b00, 2'b00, 0, 0);
    goto(26); expect_st("t1_c26", 3'd0, 2'b10, 2'b00, 0, 0);

    // 2: pedestrian pulse at cycle 3
    do_reset();
    goto(3); ped_req = 1'b1; tick(); ped_req = 1'b0;
    expect_st("t2_c4", 3'd0, 2'b10, 2'b00, 0, 1);
    goto(12); expect_st("t2_c12", 3'd2, 2'b00, 2'b00, 0, 1);
    goto(13); expect_st("t2_c13", 3'd6, 2'b00, 2'b00, 1, 0);
    goto(17); expect_st("t2_c17", 3'd6, 2'b00, 2'b00, 1, 0);
    goto(18); expect_st("t2_c18", 3'd3, 2'b00, 2'b10, 0, 0);

    // 3: emergency toward EW during NS green
    do_reset();
    goto(2); emerg_req = 1'b1; emerg_dir = 1'b1;
    goto(3);  expect_st("t3_c3", 3'd1, 2'b01, 2'b00, 0, 0);
    goto(6);  expect_st("t3_c6", 3'd2, 2'b00, 2'b00, 0, 0);
    goto(8);  expect_st("t3_c8", 3'd3, 2'b00, 2'b10, 0, 0);
    goto(20); expect_st("t3_c20", 3'd3, 2'b00, 2'b10, 0, 0);
    emerg_req = 1'b0;
    goto(27); expect_st("t3_c27", 3'd3, 2'b00, 2'b10, 0, 0);
    goto(28); expect_st("t3_c28", 3'd4, 2'b00, 2'b01, 0, 0);

    // 4: flash mode
    do_reset();
    flash_mode = 1'b1;
    goto(13); expect_st("t4_c13", 3'd7, 2'b01, 2'b01, 0, 0);
    goto(16); expect_st("t4_c16", 3'd7, 2'b01, 2'b01, 0, 0);
    goto(17); expect_st("t4_c17", 3'd7, 2'b11, 2'b11, 0, 0);
    goto(20); expect_st("t4_c20", 3'd7, 2'b11, 2'b11, 0, 0);
    goto(21); expect_st("t4_c21", 3'd7, 2'b01, 2'b01, 0, 0);
    goto(22); flash_mode = 1'b0;
    goto(24); expect_st("t4_c24", 3'd7, 2'b01, 2'b01, 0, 0);
    goto(25); expect_st("t4_c25", 3'd7, 2'b11, 2'b11, 0, 0);
    goto(28); expect_st("t4_c28", 3'd7, 2'b11, 2'b11, 0, 0);
    goto(29); expect_st("t4_c29", 3'd5, 2'b00, 2'b00, 0, 0);
    goto(30); expect_st("t4_c30", 3'd5, 2'b00, 2'b00, 0, 0);
    goto(31); expect_st("t4_c31", 3'd0, 2'b10, 2'b00, 0, 0);

    // 5: reset in the middle of EW yellow with a pending request
    do_reset();
    goto(15); ped_req = 1'b1; tick(); ped_req = 1'b0;
    expect_st("t5_c16", 3'd3, 2'b00, 2'b10, 0, 1);
    goto(22); expect_st("t5_c22", 3'd4, 2'b00, 2'b01, 0, 1);
    reset = 1'b1; tick(); reset = 1'b0; cyc = 0;
    expect_st("t5_rst", 3'd0, 2'b10, 2'b00, 0, 0);
    goto(7); expect_st("t5_c7", 3'd0, 2'b10, 2'b00, 0, 0);
    goto(8); expect_st("t5_c8", 3'd1, 2'b01, 2'b00, 0, 0);

    // 6: emergency for the direction that is already green holds the green
    do_reset();
    goto(3); emerg_req = 1'b1; emerg_dir = 1'b0;
    goto(20); expect_st("t6_c20", 3'd0, 2'b10, 2'b00, 0, 0);
    emerg_req = 1'b0;
    goto(27); expect_st("t6_c27", 3'd0, 2'b10, 2'b00, 0, 0);
    goto(28); expect_st("t6_c28", 3'd1, 2'b01, 2'b00, 0, 0);

    // 7: simultaneous ped and emergency requests, with the emergency served first
    do_reset();
    goto(2); ped_req = 1'b1; emerg_req = 1'b1; emerg_dir = 1'b1; tick(); ped_req = 1'b0;
    expect_st("t7_c3", 3'd1, 2'b01, 2'b00, 0, 1);
    goto(8);  expect_st("t7_c8", 3'd3, 2'b00, 2'b10, 0, 1);
    emerg_req = 1'b0;
    goto(15); expect_st("t7_c15", 3'd3, 2'b00, 2'b10, 0, 1);
    goto(19); expect_st("t7_c19", 3'd5, 2'b00, 2'b00, 0, 1);
    goto(21); expect_st("t7_c21", 3'd6, 2'b00, 2'b00, 1, 0);

    // 8: random soak with safety checks every cycle
    do_reset();
    last_g = 0; saw_y = 1'b0; saw_ar = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        emerg_req = ~emerg_req;
        emerg_dir = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) flash_mode = ~flash_mode;
      ped_req = ($urandom_range(0, 19) == 0);
      tick();
      bad = (ns_light inside {2'b01, 2'b10}) && (ew_light inside {2'b01, 2'b10}) &&
            !(phase == 3'd7 && ns_light == 2'b01 && ew_light == 2'b01);
      chk("rnd_heads", {8'd0, bad}, 9'd0);
      chk("rnd_walk", {8'd0, ped_walk && (ns_light != 2'b00 || ew_light != 2'b00)}, 9'd0);
      if (ns_light == 2'b10) begin
        chk("rnd_ns_after_ew", {8'd0, (last_g == 2) && !(saw_y && saw_ar)}, 9'd0);
        last_g = 1; saw_y = 1'b0; saw_ar = 1'b0;
      end else if (ew_light == 2'b10) begin
        chk("rnd_ew_after_ns", {8'd0, (last_g == 1) && !(saw_y && saw_ar)}, 9'd0);
        last_g = 2; saw_y = 1'b0; saw_ar = 1'b0;
      end else begin
        if (ns_light == 2'b01 || ew_light == 2'b01) saw_y = 1'b1;
        if (ns_light == 2'b00 && ew_light == 2'b00 && saw_y) saw_ar = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
